// File: rtl/mem_write_arbiter_pkg.sv
// Shared definitions for the two-requester memory write arbiter:
// FSM state encoding, write-response codes, size codes and the
// size-code to byte-strobe decode.
package mem_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR_DATA = 2'b01,
        ST_RESP      = 2'b10,
        ST_DONE      = 2'b11
    } state_e;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    localparam logic [3:0] WMASK_8B = 4'b1000;
    localparam logic [3:0] WMASK_4B = 4'b0100;
    localparam logic [3:0] WMASK_2B = 4'b0010;
    localparam logic [3:0] WMASK_1B = 4'b0001;

    localparam logic [2:0] AWPORT_DEFAULT = 3'b111;

    // Unknown size codes fall back to a full 8-byte strobe.
    function automatic logic [7:0] wstrb_decode(input logic [3:0] wmask);
        logic [7:0] strb;
        case (wmask)
            WMASK_8B: strb = 8'hFF;
            WMASK_4B: strb = 8'h0F;
            WMASK_2B: strb = 8'h03;
            WMASK_1B: strb = 8'h01;
            default:  strb = 8'hFF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// AXI-style write port (AW/W/B channels) between the arbiter (master)
// and physical memory (slave).
interface mem_write_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPORT;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;

    modport master (
        output AWVALID, AWADDR, AWPORT, WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPORT, WVALID, WDATA, WSTRB, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/mem_write_arb_pick.sv
// Grant selection for the write arbiter. Produces a one-hot grant only
// while the FSM is idle. Build option MEM_WRITE_ARB_RR_EN selects
// round-robin on a tie; otherwise requester 0 always wins.
module mem_write_arb_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  logic       i_idle,
    output logic [1:0] o_grant
);

`ifdef MEM_WRITE_ARB_RR_EN
    // On a tie the requester that was not granted last time wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_idle) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_ptr ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end else begin
            o_grant = 2'b00;
        end
    end
`else
    // The pointer has no meaning under fixed priority.
    logic w_ptr_unused;
    assign w_ptr_unused = i_ptr;

    // Fixed priority: requester 0 wins any tie.
    always_comb begin
        o_grant = 2'b00;
        if (i_idle) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = 2'b01;
                default: o_grant = 2'b00;
            endcase
        end else begin
            o_grant = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/mem_write_arbiter.sv
// Two-requester write controller owning the single AW/W/B write port.
// Runs one single-beat transaction at a time (IDLE -> ADDR_DATA -> RESP
// -> DONE) and pulses finish/err to the granted requester.
// Build option MEM_WRITE_ARB_RR_EN enables round-robin arbitration.
module mem_write_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req0_en,
    input  logic              req1_en,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [3:0]        req0_wmask,
    input  logic [3:0]        req1_wmask,
    output logic              req0_finish,
    output logic              req1_finish,
    output logic              req0_err,
    output logic              req1_err,
    output logic              busy,
    mem_write_arbiter_if.master axi
);

    localparam int STRB_W = DATA_W / 8;

    state_e              r_state;
    logic                r_gnt;       // 1: requester 1 owns the current transaction
    logic                r_awvalid;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_wvalid;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_wlast;
    logic                r_bready;
    logic                r_finish0;
    logic                r_finish1;
    logic                r_err0;
    logic                r_err1;
    logic                r_busy;

    logic [1:0]          w_grant;
    logic                w_ptr;
    logic                w_aw_done;
    logic                w_w_done;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [3:0]          w_sel_wmask;

`ifdef MEM_WRITE_ARB_RR_EN
    logic r_ptr;

    // Remember which requester received the most recent grant.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_ptr <= 1'b0;
        end else if (w_grant != 2'b00) begin
            r_ptr <= w_grant[1];
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    mem_write_arb_pick u_pick (
        .i_req   ({req1_en, req0_en}),
        .i_ptr   (w_ptr),
        .i_idle  (r_state == ST_IDLE),
        .o_grant (w_grant)
    );

    assign w_sel_addr  = w_grant[1] ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant[1] ? req1_wdata : req0_wdata;
    assign w_sel_wmask = w_grant[1] ? req1_wmask : req0_wmask;

    // A channel counts as complete once its valid has dropped or is being accepted now.
    assign w_aw_done = !r_awvalid || axi.AWREADY;
    assign w_w_done  = !r_wvalid  || axi.WREADY;

    // Transaction sequencer; every port-facing output is a register of this FSM.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 1'b0;
            r_awvalid <= 1'b0;
            r_awaddr  <= {ADDR_W{1'b0}};
            r_wvalid  <= 1'b0;
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_finish0 <= 1'b0;
            r_finish1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_gnt     <= w_grant[1];
                        r_awaddr  <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_wstrb   <= STRB_W'(wstrb_decode(w_sel_wmask));
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ADDR_DATA;
                    end
                end
                ST_ADDR_DATA: begin
                    if (r_awvalid && axi.AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_awaddr  <= {ADDR_W{1'b0}};
                    end
                    if (r_wvalid && axi.WREADY) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_wdata  <= {DATA_W{1'b0}};
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (axi.BVALID && r_bready) begin
                        r_bready  <= 1'b0;
                        r_finish0 <= !r_gnt;
                        r_finish1 <= r_gnt;
                        r_err0    <= !r_gnt && (axi.BRESP != BRESP_OKAY);
                        r_err1    <= r_gnt  && (axi.BRESP != BRESP_OKAY);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_finish0 <= 1'b0;
                    r_finish1 <= 1'b0;
                    r_err0    <= 1'b0;
                    r_err1    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.AWVALID = r_awvalid;
    assign axi.AWADDR  = r_awaddr;
    assign axi.AWPORT  = AWPORT_DEFAULT;
    assign axi.WVALID  = r_wvalid;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WLAST   = r_wlast;
    assign axi.BREADY  = r_bready;

    assign req0_finish = r_finish0;
    assign req1_finish = r_finish1;
    assign req0_err    = r_err0;
    assign req1_err    = r_err1;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter. A timeline model derives
// every expected output per cycle from the requested slave stall pattern.
module tb_mem_write_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req0_en, req1_en;
    logic [31:0] req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic [3:0]  req0_wmask, req1_wmask;
    logic        req0_finish, req1_finish, req0_err, req1_err, busy;

    int n_checks   = 0;
    int n_fail     = 0;
    int last_grant = 0;

    mem_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    mem_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req0_en     (req0_en),
        .req1_en     (req1_en),
        .req0_addr   (req0_addr),
        .req1_addr   (req1_addr),
        .req0_wdata  (req0_wdata),
        .req1_wdata  (req1_wdata),
        .req0_wmask  (req0_wmask),
        .req1_wmask  (req1_wmask),
        .req0_finish (req0_finish),
        .req1_finish (req1_finish),
        .req0_err    (req0_err),
        .req1_err    (req1_err),
        .busy        (busy),
        .axi         (axi)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte strobe implied by a size code.
    function automatic logic [7:0] ref_strb(input logic [3:0] m);
        if (m == 4'b0100) return 8'h0F;
        if (m == 4'b0010) return 8'h03;
        if (m == 4'b0001) return 8'h01;
        return 8'hFF;
    endfunction

    // Which requester the arbitration rule serves next.
    function automatic int ref_pick(input logic e0, input logic e1);
`ifdef MEM_WRITE_ARB_RR_EN
        if (e0 && e1) return 1 - last_grant;
`endif
        return e0 ? 0 : 1;
    endfunction

    function automatic logic [3:0] rand_mask();
        logic [3:0] codes [4];
        int sel;
        codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010; codes[3] = 4'b0001;
        sel = $urandom_range(0, 4);
        if (sel == 4) return 4'($urandom);
        return codes[sel];
    endfunction

    task automatic slave_idle();
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".awvalid"}, 64'(axi.AWVALID), 64'd0);
        chk({tag, ".awaddr"},  64'(axi.AWADDR),  64'd0);
        chk({tag, ".awport"},  64'(axi.AWPORT),  64'd7);
        chk({tag, ".wvalid"},  64'(axi.WVALID),  64'd0);
        chk({tag, ".wdata"},   axi.WDATA,        64'd0);
        chk({tag, ".wstrb"},   64'(axi.WSTRB),   64'd0);
        chk({tag, ".wlast"},   64'(axi.WLAST),   64'd0);
        chk({tag, ".bready"},  64'(axi.BREADY),  64'd0);
        chk({tag, ".fin0"},    64'(req0_finish), 64'd0);
        chk({tag, ".fin1"},    64'(req1_finish), 64'd0);
        chk({tag, ".err0"},    64'(req0_err),    64'd0);
        chk({tag, ".err1"},    64'(req1_err),    64'd0);
        chk({tag, ".busy"},    64'(busy),        64'd0);
    endtask

    // Serve one transaction. Called in the IDLE cycle whose closing edge samples en.
    // Slave accepts AW after aw_d stall cycles, W after w_d, returns B after b_d.
    task automatic do_txn(input string tag, input int aw_d, input int w_d, input int b_d,
                          input logic [1:0] bresp);
        int g, m, fin, cc;
        logic [31:0] ea;
        logic [63:0] ed;
        logic [7:0]  es;
        logic        exp_aw, exp_w;
        g  = ref_pick(req0_en, req1_en);
        last_grant = g;
        ea = (g == 1) ? req1_addr  : req0_addr;
        ed = (g == 1) ? req1_wdata : req0_wdata;
        es = ref_strb((g == 1) ? req1_wmask : req0_wmask);
        m   = (aw_d > w_d) ? aw_d : w_d;
        fin = 3 + m + b_d;
        for (int c = 0; c <= fin; c++) begin
            axi.AWREADY = (c == 1 + aw_d);
            axi.WREADY  = (c == 1 + w_d);
            axi.BVALID  = (c == 2 + m + b_d);
            axi.BRESP   = axi.BVALID ? bresp : 2'b00;
            @(posedge ACLK); #1;
            cc = c + 1;
            exp_aw = (cc <= 1 + aw_d);
            exp_w  = (cc <= 1 + w_d);
            chk({tag, ".awvalid"}, 64'(axi.AWVALID), 64'(exp_aw));
            chk({tag, ".awaddr"},  64'(axi.AWADDR),  exp_aw ? 64'(ea) : 64'd0);
            chk({tag, ".awport"},  64'(axi.AWPORT),  64'd7);
            chk({tag, ".wvalid"},  64'(axi.WVALID),  64'(exp_w));
            chk({tag, ".wlast"},   64'(axi.WLAST),   64'(exp_w));
            chk({tag, ".wdata"},   axi.WDATA,        exp_w ? ed : 64'd0);
            chk({tag, ".wstrb"},   64'(axi.WSTRB),   64'(es));
            chk({tag, ".bready"},  64'(axi.BREADY),  64'((cc >= 2 + m) && (cc <= 2 + m + b_d)));
            chk({tag, ".busy"},    64'(busy),        64'(cc <= fin));
            chk({tag, ".fin0"},    64'(req0_finish), 64'((g == 0) && (cc == fin)));
            chk({tag, ".fin1"},    64'(req1_finish), 64'((g == 1) && (cc == fin)));
            chk({tag, ".err0"},    64'(req0_err),    64'((g == 0) && (cc == fin) && (bresp != 2'b00)));
            chk({tag, ".err1"},    64'(req1_err),    64'((g == 1) && (cc == fin) && (bresp != 2'b00)));
            // The inputs of the owner are meaningless after the grant.
            if (cc == 1) begin
                if (g == 1) begin
                    req1_addr = $urandom; req1_wdata = {$urandom, $urandom}; req1_wmask = rand_mask();
                end else begin
                    req0_addr = $urandom; req0_wdata = {$urandom, $urandom}; req0_wmask = rand_mask();
                end
            end
            if (cc == fin) begin
                if (g == 1) req1_en = 1'b0;
                else        req0_en = 1'b0;
            end
        end
        slave_idle();
    endtask

    initial begin
        int pat;
        ARESETn = 1'b0;
        req0_en = 1'b0; req1_en = 1'b0;
        req0_addr = 32'd0; req1_addr = 32'd0;
        req0_wdata = 64'd0; req1_wdata = 64'd0;
        req0_wmask = 4'd0; req1_wmask = 4'd0;
        slave_idle();
        repeat (2) @(posedge ACLK);
        #1;
        check_reset("rst");
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check_reset("post_rst");

        // Single full-width write, slave always ready.
        req0_en = 1'b1; req0_addr = 32'h8000_0010;
        req0_wdata = 64'h1122_3344_5566_7788; req0_wmask = 4'b1000;
        do_txn("single", 0, 0, 0, 2'b00);

        // Simultaneous requests.
        req0_en = 1'b1; req0_addr = 32'h0000_1000; req0_wdata = 64'hA5A5_0000_0000_00A5; req0_wmask = 4'b0001;
        req1_en = 1'b1; req1_addr = 32'h0000_2000; req1_wdata = 64'h0000_0000_DEAD_BEEF; req1_wmask = 4'b0100;
        do_txn("collide_a", 0, 0, 0, 2'b00);
        do_txn("collide_b", 0, 0, 0, 2'b00);

        // Split handshakes in both orders.
        req0_en = 1'b1; req0_addr = 32'h0000_3000; req0_wdata = 64'h0123_4567_89AB_CDEF; req0_wmask = 4'b0010;
        do_txn("split_w_first", 2, 0, 0, 2'b00);
        req0_en = 1'b1; req0_addr = 32'h0000_4000; req0_wdata = 64'hFEDC_BA98_7654_3210; req0_wmask = 4'b1000;
        do_txn("split_aw_first", 0, 2, 0, 2'b00);

        // Error response after a stalled B channel.
        req1_en = 1'b1; req1_addr = 32'h0000_5000; req1_wdata = 64'h5555_AAAA_5555_AAAA; req1_wmask = 4'b1000;
        do_txn("slverr", 0, 0, 3, 2'b10);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            pat = $urandom_range(1, 3);
            if (pat != 2) begin
                req0_en = 1'b1; req0_addr = $urandom; req0_wdata = {$urandom, $urandom}; req0_wmask = rand_mask();
            end
            if (pat != 1) begin
                req1_en = 1'b1; req1_addr = $urandom; req1_wdata = {$urandom, $urandom}; req1_wmask = rand_mask();
            end
            while (req0_en || req1_en) begin
                do_txn("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       2'($urandom_range(0, 3)));
            end
        end

        // Reset while waiting for the write response.
        req0_en = 1'b1; req0_addr = 32'h0000_6000; req0_wdata = 64'h1111_2222_3333_4444; req0_wmask = 4'b1000;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("abort.awvalid_pre", 64'(axi.AWVALID), 64'd1);
        @(posedge ACLK); #1;
        chk("abort.bready_pre", 64'(axi.BREADY), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        check_reset("abort_async");
        req0_en = 1'b0;
        slave_idle();
        for (int k = 0; k < 2; k++) begin
            @(posedge ACLK); #1;
            chk("abort.fin0_hold", 64'(req0_finish), 64'd0);
            chk("abort.busy_hold", 64'(busy), 64'd0);
        end
        ARESETn = 1'b1;
        last_grant = 0;
        @(posedge ACLK); #1;
        check_reset("abort_release");
        req0_en = 1'b1; req0_addr = 32'h0000_7000; req0_wdata = 64'h7777_8888_9999_0000; req0_wmask = 4'b0100;
        do_txn("after_abort", 0, 0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
